// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side arbitration logic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SEND,
    WAIT,
    HOLD
  } arb_state_e;

  localparam int BPS_DEFAULT      = 5208;
  localparam int LOCK_TMO_DEFAULT = 10 * BPS_DEFAULT;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: picks the first set request above rr_ptr, wrapping
// modulo N_REQ. Purely combinational so the RX dispatcher can reuse it.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any_req
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest candidate down so the nearest one above rr_ptr wins.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Frame-aware round-robin sequencer sharing one uart_tx among N_REQ byte sources.
// state | meaning: IDLE no owner | ARB pick winner | SEND issue byte | WAIT serializer busy | HOLD locked, await next byte
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int LOCK_TMO = LOCK_TMO_DEFAULT,
  parameter int TMO_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  input  logic [N_REQ-1:0]   last,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         tx_din,
  output logic               tx_din_vld,
  input  logic               tx_rdy,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               lock_tmo_err
);

  arb_state_e      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            any_req;
  logic            frame_end;
  logic            wait_first;
  logic [TMO_W-1:0] tmo_cnt;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ack          <= '0;
      tx_din       <= '0;
      tx_din_vld   <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= ID_W'(N_REQ - 1);
      lock_tmo_err <= 1'b0;
      rr_ptr       <= ID_W'(N_REQ - 1);
      tmo_cnt      <= '0;
      frame_end    <= 1'b0;
      wait_first   <= 1'b0;
    end else begin
      ack          <= '0;
      tx_din_vld   <= 1'b0;
      lock_tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req && tx_rdy) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          // SEND may only be entered with the serializer ready; otherwise retry from IDLE.
          if (any_req && tx_rdy) begin
            grant_id <= winner;
            state    <= SEND;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SEND: begin
          tx_din     <= data[{grant_id, 3'b000} +: 8];
          tx_din_vld <= 1'b1;
          ack        <= N_REQ'(1) << grant_id;
          frame_end  <= last[grant_id];
          wait_first <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (tx_rdy) begin
            if (frame_end) begin
              rr_ptr <= grant_id;
              if (any_req) begin
                state <= ARB;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              state   <= HOLD;
              tmo_cnt <= '0;
            end
          end
        end
        HOLD: begin
          if (req[grant_id]) begin
            if (tx_rdy) state <= SEND;
          end else if (tmo_cnt == TMO_W'(LOCK_TMO - 1)) begin
            lock_tmo_err <= 1'b1;
            rr_ptr       <= grant_id;
            tmo_cnt      <= '0;
            if (any_req) begin
              state <= ARB;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a short-byte uart_tx stand-in and queued requesters.
module tb_uart_tx_arb;

  localparam int N_REQ    = 4;
  localparam int ID_W     = 2;
  localparam int LOCK_TMO = 200;
  localparam int TMO_W    = 16;
  localparam int BYTE_T   = 12;
  localparam int LIMIT    = 3000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   last;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         tx_din;
  logic               tx_din_vld;
  logic               tx_rdy;
  logic               busy;
  logic [ID_W-1:0]    grant_id;
  logic               lock_tmo_err;

  always #5 clk = ~clk;

  uart_tx_arb #(.N_REQ(N_REQ), .ID_W(ID_W), .LOCK_TMO(LOCK_TMO), .TMO_W(TMO_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .data         (data),
    .last         (last),
    .ack          (ack),
    .tx_din       (tx_din),
    .tx_din_vld   (tx_din_vld),
    .tx_rdy       (tx_rdy),
    .busy         (busy),
    .grant_id     (grant_id),
    .lock_tmo_err (lock_tmo_err)
  );

  // uart_tx stand-in: rdy low during din_vld and for BYTE_T cycles afterwards
  int   tx_cnt = 0;
  logic hold_low = 1'b0;
  always @(posedge clk) begin
    if (tx_din_vld) tx_cnt <= BYTE_T;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_rdy = (tx_cnt == 0) && !tx_din_vld && !hold_low;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]      q [N_REQ][$];
  logic [7:0]      sent_d [$];
  logic [ID_W-1:0] sent_id [$];
  logic [N_REQ-1:0] sent_ack [$];
  int              sent_c [$];
  int              hold_q [$];
  int n_checks = 0, n_fail = 0;
  int err_cnt = 0, err_cyc = 0, rise_cyc = 0;
  bit hold_armed = 1'b0, prev_vld = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic l);
    q[i].push_back({l, b});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N_REQ; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_log();
    sent_d.delete(); sent_id.delete(); sent_ack.delete(); sent_c.delete(); hold_q.delete();
    err_cnt    = 0;
    hold_armed = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    while (k < LIMIT && !done) begin
      @(negedge clk);
      k++;
      done = all_empty() && !busy;
    end
    check($sformatf("%s_idle_reached", nm), 32'(done), 32'd1);
  endtask

  task automatic wait_sent(input string nm, input int n);
    int k;
    k = 0;
    while (k < LIMIT && sent_d.size() < n) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s_sent_reached", nm), 32'(sent_d.size() >= n), 32'd1);
  endtask

  task automatic check_seq(input string nm, input int n, input logic [31:0] exp_b,
                           input logic [7:0] exp_id);
    logic [N_REQ-1:0] one;
    logic [ID_W-1:0]  eid;
    one = 1;
    check($sformatf("%s_count", nm), sent_d.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < sent_d.size()) begin
        eid = exp_id[2*k +: 2];
        check($sformatf("%s_byte%0d", nm, k), sent_d[k], exp_b[8*k +: 8]);
        check($sformatf("%s_grant%0d", nm, k), sent_id[k], eid);
        check($sformatf("%s_ack%0d", nm, k), sent_ack[k], one << eid);
      end
    end
  endtask

  // requester model: head of each queue is presented until acked
  initial begin : driver
    logic [N_REQ-1:0] old_req;
    logic [8:0]       cur;
    req  = '0;
    data = '0;
    last = '0;
    forever begin
      @(negedge clk);
      old_req = req;
      for (int i = 0; i < N_REQ; i++)
        if (ack[i] && q[i].size() > 0) void'(q[i].pop_front());
      for (int i = 0; i < N_REQ; i++) begin
        if (q[i].size() > 0) begin
          cur             = q[i][0];
          req[i]          = 1'b1;
          data[8*i +: 8]  = cur[7:0];
          last[i]         = cur[8];
        end else begin
          req[i] = 1'b0;
        end
      end
      if (old_req == '0 && req != '0) rise_cyc = cyc;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (tx_din_vld) begin
        check("vld_not_back_to_back", 32'(prev_vld), 32'd0);
        sent_d.push_back(tx_din);
        sent_id.push_back(grant_id);
        sent_ack.push_back(ack);
        sent_c.push_back(cyc);
        hold_armed = 1'b1;
      end else if (ack != '0) begin
        check("ack_without_vld", 32'(ack), 32'd0);
      end else if (hold_armed && tx_rdy) begin
        hold_q.push_back(cyc + 1);
        hold_armed = 1'b0;
      end
      if (lock_tmo_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      prev_vld = tx_din_vld;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  mask;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  initial begin : main
    logic [7:0] ids;
    logic [7:0] eb;
    tbl[0] = '{4'b1111, 4, 32'h13121110};
    tbl[1] = '{4'b1111, 4, 32'h13121110};
    tbl[2] = '{4'b0101, 2, 32'h00001210};
    tbl[3] = '{4'b1011, 3, 32'h00111013};
    tbl[4] = '{4'b0110, 2, 32'h00001112};
    tbl[5] = '{4'b0010, 1, 32'h00000011};
    tbl[6] = '{4'b0011, 2, 32'h00001110};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_tx_din", 32'(tx_din), 32'd0);
    check("rst_tx_din_vld", 32'(tx_din_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd3);
    check("rst_lock_tmo_err", 32'(lock_tmo_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // one-byte frames: round-robin order from the carried pointer
    for (int r = 0; r < 7; r++) begin
      clear_log();
      for (int i = 0; i < N_REQ; i++)
        if (tbl[r].mask[i]) push(i, 8'(8'h10 + i), 1'b1);
      wait_idle($sformatf("tbl%0d", r));
      ids = '0;
      for (int k = 0; k < tbl[r].n; k++) begin
        eb = tbl[r].exp[8*k +: 8];
        ids[2*k +: 2] = eb[1:0];
      end
      check_seq($sformatf("tbl%0d", r), tbl[r].n, tbl[r].exp, ids);
    end

    // two-byte frame from requester 0, latency of first and follow-on byte
    clear_log();
    push(0, 8'h55, 1'b0);
    push(0, 8'hA3, 1'b1);
    wait_idle("frame2");
    check_seq("frame2", 2, 32'h0000A355, 8'h00);
    if (sent_c.size() >= 1) check("first_byte_latency", 32'(sent_c[0] - rise_cyc), 32'd3);
    if (sent_c.size() >= 2 && hold_q.size() >= 1)
      check("follow_byte_latency", 32'(sent_c[1] - hold_q[0]), 32'd2);
    check("busy_after_frame", 32'(busy), 32'd0);

    // locked frame holds off a competing requester
    clear_log();
    push(1, 8'h01, 1'b0);
    wait_sent("locked", 1);
    push(2, 8'h22, 1'b1);
    repeat (100) @(negedge clk);
    push(1, 8'h02, 1'b1);
    wait_idle("locked");
    check_seq("locked", 3, 32'h00220201, 8'h25);
    check("locked_no_tmo", 32'(err_cnt), 32'd0);

    // stalled owner is released after LOCK_TMO idle cycles in HOLD
    clear_log();
    push(3, 8'h33, 1'b0);
    wait_sent("tmo", 1);
    push(0, 8'h44, 1'b1);
    wait_idle("tmo");
    check_seq("tmo", 2, 32'h00004433, 8'h03);
    check("tmo_err_pulses", 32'(err_cnt), 32'd1);
    if (hold_q.size() >= 1) check("tmo_err_timing", 32'(err_cyc - hold_q[0]), 32'(LOCK_TMO));

    // serializer not ready: nothing issued until rdy returns, then one pulse
    clear_log();
    hold_low = 1'b1;
    push(2, 8'h5A, 1'b1);
    repeat (30) @(negedge clk);
    check("rdy_low_no_vld", 32'(sent_d.size()), 32'd0);
    check("rdy_low_idle", 32'(busy), 32'd0);
    hold_low = 1'b0;
    wait_idle("rdy_low");
    check_seq("rdy_low", 1, 32'h0000005A, 8'h02);

    // reset during WAIT of a two-byte frame
    clear_log();
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b1);
    wait_sent("mid_rst", 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_tx_din", 32'(tx_din), 32'd0);
    check("mid_rst_tx_din_vld", 32'(tx_din_vld), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd3);
    check("mid_rst_lock_tmo_err", 32'(lock_tmo_err), 32'd0);
    for (int i = 0; i < N_REQ; i++) q[i].delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    push(2, 8'hC2, 1'b1);
    push(0, 8'hC0, 1'b1);
    wait_idle("post_rst");
    check_seq("post_rst", 2, 32'h0000C2C0, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
